seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receiving end of the Basys-3 seven-segment bus: monitors the active-LOW `seg`/`an` pins driven by the display encoders and reconstructs the four displayed hex digits. The block waits for a stable digit window, then decodes the segment pattern back to a nibble. It flags illegal segment patterns and illegal digit enables. It sits beside the display path as a loopback monitor for self-check and for the verification bench.

## Interface
- `SETTLE_CYCLES`, 4, consecutive identical samples required before capture (legal range 1–255).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `seg_in`  in  7  observed segments `{g..a}`, bit0 = a, active-LOW (0 = lit).
- `an_in`  in  4  observed digit enables, active-LOW.
- `digits`  out  16  decoded nibbles; digit i is held in `[4i+3:4i]`.
- `digit_valid`  out  4  bit i = digit i holds a decoded hex value.
- `cap_stb`  out  1  one-cycle pulse on every successful capture.
- `frame_done`  out  1  one-cycle pulse when all four digits have been captured since the previous pulse.
- `bad_seg`  out  4  sticky; bit i = an illegal pattern was seen on digit i.
- `an_err`  out  1  sticky; a multi-hot `an` was seen.

## Operation
- Input stage: `{an_in, seg_in}` is registered into `s`, and `s_prev` holds the previous `s`.
- A window is valid when exactly one `an` bit of `s` is 0. Digit index i is the position of that zero bit.
- FSM states:
  - IDLE → SETTLE on a valid window.
  - SETTLE → CAPTURED when `cnt == SETTLE_CYCLES-1` with `s == s_prev`.
  - SETTLE or CAPTURED → SETTLE on any change of `s` to another valid window, with `cnt` cleared.
  - Any state → IDLE when `an == 4'b1111` (blank) or `an` is multi-hot.
- `cnt` is 8 bits and increments while `s == s_prev` in SETTLE. Only one capture is made per stable window: CAPTURED does not recapture.
- Capture of digit i, by pattern:
  - Pattern is one of the 16 hex codes (0=`1000000` … F=`0001110`): write the nibble to `digits[4i+:4]`, set `digit_valid[i]`, pulse `cap_stb`, set `seen[i]`.
  - Pattern is `1111111` (blank): clear `digit_valid[i]`, keep the nibble, set `seen[i]`, no `cap_stb`.
  - Any other pattern: set `bad_seg[i]`, leave digit i unchanged, no `cap_stb`, `seen` unaffected.
- A multi-hot `an` sets `an_err`. No capture is made.
- `frame_done` pulses in the cycle after the update that makes `seen == 4'b1111`. `seen` clears in that same update, and a capture in that cycle is counted in the new frame.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: `digits` = 0, `digit_valid` = 0, `cap_stb` = 0, `frame_done` = 0, `bad_seg` = 0, `an_err` = 0. FSM resets to IDLE, `cnt` = 0, `seen` = 0.
- Reset asserted mid-SETTLE abandons the window. No capture is made after release until a fresh stable window occurs.
- Latency from pins stable at edge N to outputs updated: edge N + SETTLE_CYCLES + 1. Add 2 edges with `SEG_SYNC_EN`.
- `cap_stb` and `frame_done` are registered, single-cycle, and never back-to-back within one window.
- A glitch of fewer than SETTLE_CYCLES samples produces no capture and no error.

## Configuration
- `SEG_SYNC_EN` defined: a 2-flop synchronizer is placed per input bit ahead of `s`, for pins from an external board or another clock. Adds 2 cycles of latency.
- `SEG_SYNC_EN` undefined: pins feed `s` directly. For on-chip loopback only.

## Structure
- Shared package `seg_pkg`:
  - 16 active-LOW hex pattern constants.
  - `SEG_BLANK` = `7'b1111111`.
  - `AN_NONE` = `4'b1111`.
  - FSM state typedef.
- Sub-module `seg7_decode`: combinational; `seg[6:0]` → `nib[3:0]`, `legal`, `blank`. It is shared with future display checkers.

## Test plan
- SETTLE=4, `an`=`1110`, `seg`=`0110000` held 8 cycles → `digits[3:0]`=3, `digit_valid`=`0001`, exactly one `cap_stb` at edge 5.
- `seg`=`0110000` for 2 cycles, then `0100100` held → only digit value 2 captured, no capture of 3.
- Scan digits 0–3 with 1, 2, 3, 4, 6 cycles each → `digits`=`16'h4321`, `digit_valid`=`1111`, one `frame_done` pulse.
- `an`=`1101`, `seg`=`1111110` held → `bad_seg`=`0010` sticky, `digits[7:4]` unchanged. Then `seg`=`1111111` → `digit_valid[1]`=0, no error.
- `an`=`1100` held 10 cycles → `an_err`=1, no `cap_stb`. `rst` mid-SETTLE → all outputs 0, no spurious capture after release.
- With `SEG_SYNC_EN`, repeat the first scenario → `cap_stb` at edge 7.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-LOW hex patterns, blank codes, scan FSM state.
// Bit order of every pattern is {g,f,e,d,c,b,a}; 0 means the segment is lit.
package seg_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_NONE   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } seg_state_t;

    // Number of digit enables driven low (lit) in an active-LOW an word.
    function automatic logic [2:0] an_lit_count(input logic [3:0] an);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~an[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the seven-segment encoder: active-LOW pattern back to a nibble.
// legal marks one of the 16 hex glyphs; blank marks the all-dark pattern.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nib,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        nib   = 4'h0;
        legal = 1'b1;
        blank = 1'b0;
        case (seg)
            SEG_HEX_0: nib = 4'h0;
            SEG_HEX_1: nib = 4'h1;
            SEG_HEX_2: nib = 4'h2;
            SEG_HEX_3: nib = 4'h3;
            SEG_HEX_4: nib = 4'h4;
            SEG_HEX_5: nib = 4'h5;
            SEG_HEX_6: nib = 4'h6;
            SEG_HEX_7: nib = 4'h7;
            SEG_HEX_8: nib = 4'h8;
            SEG_HEX_9: nib = 4'h9;
            SEG_HEX_A: nib = 4'hA;
            SEG_HEX_B: nib = 4'hB;
            SEG_HEX_C: nib = 4'hC;
            SEG_HEX_D: nib = 4'hD;
            SEG_HEX_E: nib = 4'hE;
            SEG_HEX_F: nib = 4'hF;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Loopback monitor for the multiplexed seven-segment bus: waits for a stable digit
// window and decodes it. Define SEG_SYNC_EN to add a 2-flop synchronizer on the pins.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        cap_stb,
    output logic        frame_done,
    output logic [3:0]  bad_seg,
    output logic        an_err,
    output logic [1:0]  state_dbg
);

    localparam logic [7:0]  CNT_LAST   = 8'(SETTLE_CYCLES - 1);
    localparam logic [10:0] PINS_QUIET = {AN_NONE, SEG_BLANK};

    logic [10:0] pins;
    logic [10:0] s;
    logic [10:0] s_prev;
    logic [3:0]  an_s;
    logic [6:0]  seg_s;
    logic [2:0]  lit_cnt;
    logic        win_valid;
    logic        win_multi;
    logic        s_changed;
    logic [3:0]  win_mask;

    seg_state_t  state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        capture;

    logic [3:0]  dec_nib;
    logic        dec_legal;
    logic        dec_blank;
    logic [3:0]  seen;
    logic [3:0]  seen_set;

`ifdef SEG_SYNC_EN
    logic [10:0] sync_a;
    logic [10:0] sync_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= PINS_QUIET;
            sync_b <= PINS_QUIET;
        end else begin
            sync_a <= {an_in, seg_in};
            sync_b <= sync_a;
        end
    end

    assign pins = sync_b;
`else
    assign pins = {an_in, seg_in};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s      <= PINS_QUIET;
            s_prev <= PINS_QUIET;
        end else begin
            s      <= pins;
            s_prev <= s;
        end
    end

    assign an_s      = s[10:7];
    assign seg_s     = s[6:0];
    assign lit_cnt   = an_lit_count(an_s);
    assign win_valid = (lit_cnt == 3'd1);
    assign win_multi = (lit_cnt > 3'd1);
    assign win_mask  = ~an_s;
    assign s_changed = (s != s_prev);

    seg7_decode u_dec (
        .seg   (seg_s),
        .nib   (dec_nib),
        .legal (dec_legal),
        .blank (dec_blank)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // One decision per stable window: capture fires only on the SETTLE->CAPTURED step.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        if (!win_valid) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                end
                ST_SETTLE: begin
                    if (s_changed) begin
                        cnt_n = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_n = ST_CAPTURED;
                        capture = 1'b1;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                ST_CAPTURED: begin
                    if (s_changed) begin
                        state_n = ST_SETTLE;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign state_dbg = state;
    assign seen_set  = (capture && (dec_legal || dec_blank)) ? win_mask : 4'b0000;

    // cap_stb qualifies the freshly written digit for one cycle; there is no backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_valid <= '0;
            cap_stb     <= 1'b0;
            frame_done  <= 1'b0;
            bad_seg     <= '0;
            an_err      <= 1'b0;
            seen        <= '0;
        end else begin
            cap_stb    <= capture && dec_legal;
            frame_done <= (seen == 4'b1111);
            seen       <= ((seen == 4'b1111) ? 4'b0000 : seen) | seen_set;
            if (win_multi) begin
                an_err <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (capture && win_mask[i]) begin
                    if (dec_legal) begin
                        digits[4*i +: 4] <= dec_nib;
                        digit_valid[i]   <= 1'b1;
                    end else if (dec_blank) begin
                        digit_valid[i] <= 1'b0;
                    end else begin
                        bad_seg[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: scenario tasks drive the pins, captures are matched
// against an expected queue of {digit index, nibble}.
module tb_seg_scan_decoder;

    localparam int SETTLE = 4;
`ifdef SEG_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int CAP_LAT = SETTLE + 1 + SYNC_LAT;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        cap_stb;
    logic        frame_done;
    logic [3:0]  bad_seg;
    logic        an_err;
    logic [1:0]  state_dbg;

    seg_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits      (digits),
        .digit_valid (digit_valid),
        .cap_stb     (cap_stb),
        .frame_done  (frame_done),
        .bad_seg     (bad_seg),
        .an_err      (an_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int cap_total = 0;
    int frame_total = 0;
    int last_cap_cyc = 0;

    logic [5:0]  exp_q[$];
    logic [15:0] exp_digits = '0;
    logic [3:0]  exp_valid = '0;
    logic [3:0]  exp_bad = '0;
    logic        exp_err = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: every cap_stb must match the head of the expected queue.
    always @(negedge clk) begin
        logic [5:0] item;
        if (frame_done) frame_total++;
        if (cap_stb) begin
            cap_total++;
            last_cap_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL cap_unexpected: cap_stb seen with digits=%h, none expected", digits);
            end else begin
                item = exp_q.pop_front();
                if (digits[item[5:4]*4 +: 4] !== item[3:0] || digit_valid[item[5:4]] !== 1'b1) begin
                    fails++;
                    $display("FAIL cap_value: digit %0d got %h valid %b, expected %h valid 1",
                             item[5:4], digits[item[5:4]*4 +: 4], digit_valid[item[5:4]], item[3:0]);
                end
            end
        end
    end

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic go_idle(input int n);
        hold(4'b1111, 7'b1111111, n);
    endtask

    task automatic check_state(input string name);
        checks++;
        if (digits !== exp_digits || digit_valid !== exp_valid || bad_seg !== exp_bad || an_err !== exp_err) begin
            fails++;
            $display("FAIL %s: got digits=%h valid=%b bad=%b err=%b, expected digits=%h valid=%b bad=%b err=%b",
                     name, digits, digit_valid, bad_seg, an_err, exp_digits, exp_valid, exp_bad, exp_err);
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_pending: %0d expected captures never seen, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        an_in = 4'b1111;
        seg_in = 7'b1111111;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({digits, digit_valid, cap_stb, frame_done, bad_seg, an_err} !== 27'd0) begin
            fails++;
            $display("FAIL reset_values: got digits=%h valid=%b cap=%b frame=%b bad=%b err=%b, expected all 0",
                     digits, digit_valid, cap_stb, frame_done, bad_seg, an_err);
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d expected 0", state_dbg);
        end
    endtask

    task automatic test_single_capture();
        int c0, start;
        c0 = cap_total;
        start = cyc;
        exp_q.push_back({2'd0, 4'h3});
        exp_digits[3:0] = 4'h3;
        exp_valid[0] = 1'b1;
        hold(4'b1110, seg_of(4'h3), 8);
        go_idle(6);
        checks++;
        if (cap_total - c0 != 1) begin
            fails++;
            $display("FAIL single_cap_count: got %0d captures, expected 1", cap_total - c0);
        end
        checks++;
        if (last_cap_cyc != start + 1 + CAP_LAT) begin
            fails++;
            $display("FAIL single_cap_latency: cap at edge %0d, expected edge %0d",
                     last_cap_cyc - start - 1, CAP_LAT);
        end
        check_state("single_capture");
    endtask

    task automatic test_glitch();
        int c0;
        c0 = cap_total;
        exp_q.push_back({2'd0, 4'h2});
        exp_digits[3:0] = 4'h2;
        hold(4'b1110, seg_of(4'h3), 2);
        hold(4'b1110, seg_of(4'h2), 8);
        go_idle(6);
        checks++;
        if (cap_total - c0 != 1) begin
            fails++;
            $display("FAIL glitch_cap_count: got %0d captures, expected 1", cap_total - c0);
        end
        check_state("glitch");
    endtask

    task automatic test_frame_scan();
        int f0;
        f0 = frame_total;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({2'(i), 4'(i + 1)});
            exp_digits[i*4 +: 4] = 4'(i + 1);
            exp_valid[i] = 1'b1;
            hold(~(4'b0001 << i), seg_of(4'(i + 1)), 6);
        end
        go_idle(8);
        checks++;
        if (digits !== 16'h4321 || digit_valid !== 4'b1111) begin
            fails++;
            $display("FAIL frame_digits: got %h valid %b, expected 4321 valid 1111", digits, digit_valid);
        end
        checks++;
        if (frame_total - f0 != 1) begin
            fails++;
            $display("FAIL frame_done_count: got %0d pulses, expected 1", frame_total - f0);
        end
        check_state("frame_scan");
    endtask

    task automatic test_bad_seg_blank();
        int c0;
        c0 = cap_total;
        exp_bad[1] = 1'b1;
        hold(4'b1101, 7'b1111110, 8);
        check_state("bad_seg");
        exp_valid[1] = 1'b0;
        hold(4'b1101, 7'b1111111, 8);
        go_idle(6);
        check_state("blank_digit");
        checks++;
        if (cap_total != c0) begin
            fails++;
            $display("FAIL bad_blank_no_cap: got %0d captures, expected 0", cap_total - c0);
        end
    endtask

    task automatic test_an_err();
        int c0;
        c0 = cap_total;
        exp_err = 1'b1;
        hold(4'b1100, seg_of(4'h5), 10);
        go_idle(4);
        checks++;
        if (cap_total != c0) begin
            fails++;
            $display("FAIL an_err_no_cap: got %0d captures, expected 0", cap_total - c0);
        end
        check_state("an_err");
    endtask

    task automatic test_random();
        logic [1:0] ri;
        logic [3:0] rv;
        int len;
        for (int k = 0; k < 12; k++) begin
            ri = 2'($urandom_range(0, 3));
            rv = 4'($urandom_range(0, 15));
            len = $urandom_range(6, 9);
            exp_q.push_back({ri, rv});
            exp_digits[ri*4 +: 4] = rv;
            exp_valid[ri] = 1'b1;
            hold(~(4'b0001 << ri), seg_of(rv), len);
            go_idle(1);
        end
        go_idle(6);
        check_state("random");
    endtask

    task automatic test_reset_mid_settle();
        int c0;
        hold(4'b1110, seg_of(4'h8), 2);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({digits, digit_valid, cap_stb, frame_done, bad_seg, an_err} !== 27'd0) begin
            fails++;
            $display("FAIL mid_reset_values: got digits=%h valid=%b cap=%b frame=%b bad=%b err=%b, expected all 0",
                     digits, digit_valid, cap_stb, frame_done, bad_seg, an_err);
        end
        an_in = 4'b1111;
        seg_in = 7'b1111111;
        @(negedge clk);
        rst = 1'b0;
        c0 = cap_total;
        exp_digits = '0;
        exp_valid = '0;
        exp_bad = '0;
        exp_err = 1'b0;
        go_idle(10);
        checks++;
        if (cap_total != c0) begin
            fails++;
            $display("FAIL mid_reset_spurious: got %0d captures after release, expected 0", cap_total - c0);
        end
        check_state("mid_reset");
    endtask

    initial begin
        rst = 1'b1;
        an_in = 4'b1111;
        seg_in = 7'b1111111;
        @(negedge clk);
        test_reset();
        test_single_capture();
        test_glitch();
        test_frame_scan();
        test_bad_seg_blank();
        test_an_err();
        test_random();
        test_reset_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
